// File: rtl/irq_sequencer.sv
// Interrupt/reset entry sequencer: owns the address bus and PC/SP strobes for the
// five-cycle RESET, NMI, IRQ and BRK entry sequences of the 8-bit core.
module irq_sequencer #(
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        nmi,
  input  logic        irq,
  input  logic        i_flag,
  input  logic        insn_done,
  input  logic        brk_req,
  input  logic [7:0]  sp,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        rw,
  output logic [1:0]  push_sel,
  output logic        b_flag,
  output logic        sp_dec,
  output logic        pcl_load,
  output logic        pch_load,
  output logic        set_i,
  output logic [1:0]  cause,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_PCH = 3'd1,
    PUSH_PCL = 3'd2,
    PUSH_P   = 3'd3,
    VEC_LO   = 3'd4,
    VEC_HI   = 3'd5
  } state_t;

  localparam logic [1:0] C_RESET = 2'b00;
  localparam logic [1:0] C_NMI   = 2'b01;
  localparam logic [1:0] C_IRQ   = 2'b10;
  localparam logic [1:0] C_BRK   = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [15:0] vec_q, vec_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic        nmi_edge;
  logic        nmi_clr;
  logic        stb_en;

  // nmi_prev resets high so an NMI held through reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PUSH_PCH;
      cause_q    <= C_RESET;
      vec_q      <= RST_VEC;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      vec_q      <= vec_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    vec_d      = vec_q;
    nmi_clr    = 1'b0;
    nmi_edge   = nmi & ~nmi_prev_q;
    nmi_prev_d = nmi;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (insn_done) begin
            if (nmi_pend_q) begin
              state_d = PUSH_PCH;
              cause_d = C_NMI;
              nmi_clr = 1'b1;
            end else if (brk_req) begin
              state_d = PUSH_PCH;
              cause_d = C_BRK;
            end else if (irq && !i_flag) begin
              state_d = PUSH_PCH;
              cause_d = C_IRQ;
            end
          end
        end
        PUSH_PCH: state_d = PUSH_PCL;
        PUSH_PCL: state_d = PUSH_P;
        PUSH_P: begin
          state_d = VEC_LO;
          // A pending NMI takes over an IRQ/BRK entry before its vector fetch.
          case (cause_q)
            C_RESET: vec_d = RST_VEC;
            C_NMI:   vec_d = NMI_VEC;
            default: begin
              if (nmi_pend_q) begin
                vec_d   = NMI_VEC;
                cause_d = C_NMI;
                nmi_clr = 1'b1;
              end else begin
                vec_d = IRQ_VEC;
              end
            end
          endcase
        end
        VEC_LO:  state_d = VEC_HI;
        VEC_HI:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);
  end

  assign stb_en = rdy & ~rst;

  always_comb begin
    busy     = 1'b1;
    addr_out = {STACK_PAGE, sp};
    rw       = 1'b1;
    push_sel = 2'b00;
    b_flag   = (cause_q == C_BRK);
    sp_dec   = 1'b0;
    pcl_load = 1'b0;
    pch_load = 1'b0;
    set_i    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        addr_out = 16'h0000;
      end
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        sp_dec = stb_en;
        // RESET performs dummy reads on the stack page instead of pushes.
        if (cause_q != C_RESET) begin
          rw = 1'b0;
          case (state_q)
            PUSH_PCH: push_sel = 2'b01;
            PUSH_PCL: push_sel = 2'b10;
            default:  push_sel = 2'b11;
          endcase
        end
      end
      VEC_LO: begin
        addr_out = vec_q;
        pcl_load = stb_en;
        set_i    = stb_en;
      end
      VEC_HI: begin
        addr_out = vec_q + 16'd1;
        pch_load = stb_en;
        done     = stb_en;
      end
      default: begin
        busy     = 1'b0;
        addr_out = 16'h0000;
      end
    endcase
  end

  assign cause = cause_q;

endmodule
